// File: rtl/audio_play_sched.sv
// Sample scheduler between the tone ROM, the line-in path and the codec FIFO handshake.
// Plays ROM words one per accepted sample, or passes line-in through; ADC FIFO kept drained.
module audio_play_sched #(
  parameter int unsigned ROM_DEPTH = 48000,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ROM_LAT   = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              play_en,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              loop_wrap
);

  typedef enum logic [1:0] {StIdle, StPrefetch, StHold} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [2:0]        LatInit  = 3'(ROM_LAT - 1);

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [2:0]          r_lat, w_lat_next;
  logic [DATA_W-1:0]   r_hold, w_hold_next;
  logic                w_read, w_write, w_wrap;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_lat   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_lat   <= w_lat_next;
      r_hold  <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_lat_next      = r_lat;
    w_hold_next     = r_hold;
    w_read          = 1'b0;
    w_write         = 1'b0;
    w_wrap          = 1'b0;
    writedata_left  = r_hold;
    writedata_right = r_hold;
    unique case (r_state)
      StIdle: begin
        writedata_left  = readdata_left;
        writedata_right = readdata_right;
        w_addr_next     = '0;
        if (play_en) begin
          w_state_next = StPrefetch;
          w_lat_next   = LatInit;
        end else if (read_ready && write_ready) begin
          w_read  = 1'b1;
          w_write = 1'b1;
        end
      end
      StPrefetch: begin
        if (!play_en) begin
          w_state_next = StIdle;
          w_addr_next  = '0;
        end else if (r_lat == 3'd0) begin
          w_hold_next  = rom_q;
          w_state_next = StHold;
        end else begin
          w_lat_next = r_lat - 3'd1;
        end
      end
      StHold: begin
        // A falling play_en beats a concurrent write_ready.
        if (!play_en) begin
          w_state_next = StIdle;
          w_addr_next  = '0;
        end else if (write_ready) begin
          w_write      = 1'b1;
          w_read       = read_ready;
          w_state_next = StPrefetch;
          w_lat_next   = LatInit;
          if (r_addr == LastAddr) begin
            w_addr_next = '0;
            w_wrap      = 1'b1;
          end else begin
            w_addr_next = r_addr + ADDR_W'(1);
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_addr_next  = '0;
      end
    endcase
  end

  assign rom_addr  = r_addr;
  assign read      = w_read && !reset;
  assign write     = w_write && !reset;
  assign loop_wrap = w_wrap && !reset;

endmodule

// File: tb/tb_audio_play_sched.sv
// Bench for audio_play_sched: directed scenarios plus random traffic, checked against
// a sample-index/ready-time model of the scheduler.
module tb_audio_play_sched;

  localparam int unsigned Depth = 4;
  localparam int unsigned Lat   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play_en = 1'b0;
  logic        read_ready = 1'b0;
  logic        write_ready = 1'b0;
  logic [23:0] readdata_left = '0;
  logic [23:0] readdata_right = '0;
  logic [23:0] rom_q;
  logic [15:0] rom_addr;
  logic        read, write, loop_wrap;
  logic [23:0] writedata_left, writedata_right;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: play mode, next sample index, cycle the sample is ready.
  bit      m_play  = 1'b0;
  bit      m_known = 1'b0;
  int      m_k     = 0;
  longint  m_ready = 0;
  longint  cyc_n   = 0;

  always #5 clk = ~clk;

  // ROM with two-cycle latency: one registered stage after the address register.
  always_ff @(posedge clk) rom_q <= 24'(rom_addr) + 24'h100;

  audio_play_sched #(
    .ROM_DEPTH(Depth),
    .ADDR_W   (16),
    .DATA_W   (24),
    .ROM_LAT  (Lat)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .play_en        (play_en),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .rom_q          (rom_q),
    .rom_addr       (rom_addr),
    .read           (read),
    .write          (write),
    .writedata_left (writedata_left),
    .writedata_right(writedata_right),
    .loop_wrap      (loop_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit play, input bit rr, input bit wr);
    logic [23:0] l, r;
    bit e_w, e_r, e_wrap;
    l = 24'($urandom);
    r = 24'($urandom);
    @(negedge clk);
    reset = rst; play_en = play; read_ready = rr; write_ready = wr;
    readdata_left = l; readdata_right = r;
    #1;
    e_w = 1'b0; e_r = 1'b0; e_wrap = 1'b0;
    if (!rst) begin
      if (!m_play) begin
        e_w = rr && wr && !play;
        e_r = e_w;
        chk("pass_left", 32'(writedata_left), 32'(l));
        chk("pass_right", 32'(writedata_right), 32'(r));
      end else if (play && cyc_n >= m_ready && wr) begin
        e_w    = 1'b1;
        e_r    = rr;
        e_wrap = (m_k == Depth - 1);
        chk("play_left", 32'(writedata_left), 32'(m_k + 'h100));
        chk("play_right", 32'(writedata_right), 32'(m_k + 'h100));
      end
    end
    chk("write", 32'(write), 32'(e_w));
    chk("read", 32'(read), 32'(e_r));
    chk("loop_wrap", 32'(loop_wrap), 32'(e_wrap));
    if (m_known) chk("rom_addr", 32'(rom_addr), 32'(m_k));
    if (rst) begin
      m_play = 1'b0; m_k = 0; m_known = 1'b1;
    end else if (!m_play) begin
      if (play) begin
        m_play  = 1'b1;
        m_ready = cyc_n + Lat + 1;
      end
    end else if (!play) begin
      m_play = 1'b0; m_k = 0;
    end else if (e_w) begin
      m_k     = (m_k + 1) % Depth;
      m_ready = cyc_n + Lat + 1;
    end
    cyc_n++;
  endtask

  initial begin
    // Reset with everything asserted.
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Passthrough: one strobe cycle with fixed data, then idle.
    @(negedge clk);
    reset = 1'b0; play_en = 1'b0; read_ready = 1'b1; write_ready = 1'b1;
    readdata_left = 24'h123456; readdata_right = 24'hABCDEF;
    #1;
    chk("pt_fixed_left", 32'(writedata_left), 32'h123456);
    chk("pt_fixed_right", 32'(writedata_right), 32'hABCDEF);
    chk("pt_fixed_write", 32'(write), 32'd1);
    chk("pt_fixed_addr", 32'(rom_addr), 32'd0);
    cyc_n++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Playback across two ROM loops with write_ready held high.
    repeat (26) cycle(1'b0, 1'b1, 1'b0, 1'b1);

    // Backpressure in HOLD, then release.
    repeat (103) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);

    // Abort: reach HOLD, then drop play_en as write_ready rises.
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset mid-PREFETCH, then restart.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bit p;
      p = ($urandom_range(0, 39) == 0) ? !play_en : play_en;
      cycle(($urandom_range(0, 199) == 0), p, 1'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
